// File: rtl/maxpool_pkg.sv
// Shared definitions for the 2x2 pooling / unpooling blocks:
// default sample width, argmax position codes and the unpool row state.
package maxpool_pkg;

   localparam int DATA_BITS_DEF = 8;

   // Position of the max element inside its 2x2 window.
   localparam logic [1:0] IDX_TL = 2'd0;
   localparam logic [1:0] IDX_TR = 2'd1;
   localparam logic [1:0] IDX_BL = 2'd2;
   localparam logic [1:0] IDX_BR = 2'd3;

   typedef enum logic {
      ST_TOP = 1'b0,
      ST_BOT = 1'b1
   } state_t;

endpackage

// File: rtl/maxunpool_linebuf.sv
// One pooled row of {data, idx} entries, written while the top output row
// is produced and replayed (combinational read) for the bottom output row.
module maxunpool_linebuf #(
   parameter int DEPTH = 14,
   parameter int WIDTH = 10,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Contents need no reset: every entry is written before it is read.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/maxunpool_2x2.sv
// 2x2 max-unpool: each pooled sample is placed at its argmax position in a
// 2x2 window (others zero), emitted as a 2x-upsampled row-major stream.
module maxunpool_2x2
   import maxpool_pkg::*;
#(
   parameter int DATA_BITS = DATA_BITS_DEF,
   parameter int IN_W      = 14,
   parameter int IN_H      = 14
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_BITS-1:0] in_data,
   input  logic [1:0]           in_idx,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_BITS-1:0] out_data,
   output logic                 out_last,
   output logic                 frame_done
);

   // Handshake: a transfer happens on a clock edge where valid && ready;
   // the producer holds data stable until then, and out_data/out_last
   // are registered and held while out_valid && !out_ready.

   localparam int CW  = (IN_W > 1) ? $clog2(IN_W) : 1;
   localparam int RW  = (IN_H > 1) ? $clog2(IN_H) : 1;
   localparam int LBW = DATA_BITS + 2;
   localparam logic [CW-1:0] COL_LAST = CW'(IN_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IN_H - 1);

   state_t               state, state_nx;
   logic [CW-1:0]        col, col_nx;
   logic [RW-1:0]        row, row_nx;
   logic                 phase, phase_nx;
   logic                 live;
   logic                 slot_free;
   logic                 in_fire;
   logic                 load;
   logic [DATA_BITS-1:0] ld_data;
   logic                 ld_last;
   logic [LBW-1:0]       lb_rdata;
   logic [DATA_BITS-1:0] rd_data;
   logic [1:0]           rd_idx;

   maxunpool_linebuf #(
      .DEPTH (IN_W),
      .WIDTH (LBW),
      .AW    (CW)
   ) u_linebuf (
      .clk   (clk),
      .we    (in_fire),
      .waddr (col),
      .wdata ({in_data, in_idx}),
      .raddr (col),
      .rdata (lb_rdata)
   );

   assign rd_data   = lb_rdata[LBW-1:2];
   assign rd_idx    = lb_rdata[1:0];
   assign slot_free = !out_valid || out_ready;
   // live keeps in_ready low while reset is held.
   assign in_ready  = live && (state == ST_TOP) && !phase && slot_free;
   assign in_fire   = in_valid && in_ready;

   always_comb begin
      state_nx = state;
      col_nx   = col;
      row_nx   = row;
      phase_nx = phase;
      load     = 1'b0;
      ld_data  = '0;
      ld_last  = 1'b0;
      case (state)
         ST_TOP: begin
            if (!phase) begin
               if (in_fire) begin
                  load     = 1'b1;
                  ld_data  = (in_idx == IDX_TL) ? in_data : '0;
                  phase_nx = 1'b1;
               end
            end else if (slot_free) begin
               load     = 1'b1;
               ld_data  = (rd_idx == IDX_TR) ? rd_data : '0;
               phase_nx = 1'b0;
               if (col == COL_LAST) begin
                  col_nx   = '0;
                  state_nx = ST_BOT;
               end else begin
                  col_nx = col + 1'b1;
               end
            end
         end
         ST_BOT: begin
            if (slot_free) begin
               load     = 1'b1;
               phase_nx = !phase;
               if (!phase) begin
                  ld_data = (rd_idx == IDX_BL) ? rd_data : '0;
               end else begin
                  ld_data = (rd_idx == IDX_BR) ? rd_data : '0;
                  if (col == COL_LAST) begin
                     col_nx   = '0;
                     state_nx = ST_TOP;
                     ld_last  = (row == ROW_LAST);
                     row_nx   = (row == ROW_LAST) ? '0 : row + 1'b1;
                  end else begin
                     col_nx = col + 1'b1;
                  end
               end
            end
         end
         default: state_nx = ST_TOP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_TOP;
         col        <= '0;
         row        <= '0;
         phase      <= 1'b0;
         live       <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_last   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         live       <= 1'b1;
         state      <= state_nx;
         col        <= col_nx;
         row        <= row_nx;
         phase      <= phase_nx;
         frame_done <= out_valid && out_ready && out_last;
         if (load) begin
            out_valid <= 1'b1;
            out_data  <= ld_data;
            out_last  <= ld_last;
         end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

endmodule

// File: doc/maxunpool_2x2.md
Name: maxunpool_2x2

Overview:
- Inverse of the 2x2 max-pool stage, used on the decoder/upsampling side of the network.
- Accepts a row-major stream of pooled signed values, each with the 2-bit position index of the window element that held the max.
- Emits a 2x-upsampled row-major stream. Each value is placed at its recorded position; the other three positions of its 2x2 window are zero.
- Uses a one-row line buffer to replay the pooled row for the second (bottom) output row.

Parameters:
- DATA_BITS, 8, width of signed data samples.
- IN_W, 14, pooled row width in pixels (>=1).
- IN_H, 14, pooled rows per frame (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  pooled sample valid.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  DATA_BITS  signed pooled value.
- in_idx  input  2  argmax position: 0=top-left, 1=top-right, 2=bottom-left, 3=bottom-right.
- out_valid  output  1  output sample valid.
- out_ready  input  1  downstream accepts output.
- out_data  output  DATA_BITS  signed upsampled value.
- out_last  output  1  high with the final output sample of a frame.
- frame_done  output  1  one-cycle pulse after the final output sample is accepted.

Behaviour:
- Reset (rst_n=0 at a clk edge, synchronous, active-low):
  - in_ready=0, out_valid=0, out_data=0, out_last=0, frame_done=0.
  - State TOP; col=0, row=0, phase=0.
  - Reset mid-frame discards all partial data; no output is produced for that frame.
  - in_ready may rise on the first cycle after reset is released.
- Handshakes:
  - Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
  - out_data/out_last are registered and held stable while out_valid && !out_ready.
- State TOP (emits output row 2r):
  - in_ready = (phase==0) && (!out_valid || out_ready).
  - On input transfer: write {in_data, in_idx} to linebuf[col]. Load out_data = (in_idx==0) ? in_data : 0. Set out_valid; phase=1.
  - phase=1, when the output slot frees: out_data = (idx==1) ? data : 0; phase=0; col++.
  - After col wraps from IN_W-1 to 0: go to BOT.
- State BOT (emits output row 2r+1):
  - in_ready=0. Reads linebuf[col].
  - phase 0 emits (idx==2) ? data : 0; phase 1 emits (idx==3) ? data : 0.
  - After the last column: row++ and return to TOP. If row was IN_H-1, row=0 and the frame ends.
- out_last: set with the phase-1 sample of BOT at col=IN_W-1, row=IN_H-1.
- frame_done: pulses the cycle after that sample's output transfer.
- Latency: first out_valid is the cycle after the first input transfer.
- Throughput: one output per cycle with out_ready held high.
- Totals per frame: 4*IN_W*IN_H outputs, IN_W*IN_H inputs.
- Counter widths: col is $clog2(IN_W) bits (min 1), row is $clog2(IN_H) bits (min 1). Both wrap exactly at IN_W-1 and IN_H-1.
- Boundary cases:
  - IN_W=1: TOP and BOT each last 2 outputs.
  - Back-pressure: out_ready low for any number of cycles stalls all state, counters and the buffer, with no loss or duplication.
  - in_valid while in BOT is ignored; the source must hold the sample.
  - Next frame starts immediately in TOP with no idle cycle required.
- Data: values pass bit-exact, with no sign alteration. Non-selected positions are exactly 0.

Decomposition:
- Shared package maxpool_pkg:
  - DATA_BITS default.
  - Index encodings IDX_TL=2'd0, IDX_TR=2'd1, IDX_BL=2'd2, IDX_BR=2'd3.
  - State encoding TOP/BOT.
- One sub-module: maxunpool_linebuf. IN_W-deep register array, width DATA_BITS+2, one synchronous write port, combinational read port. No reset on contents.

Test Plan:
- IN_W=2, IN_H=1, out_ready=1. Inputs (5,idx0), (-3,idx3).
  - Outputs row0: 5,0,0,0. Row1: 0,0,0,-3.
  - out_last on the 8th output; frame_done the next cycle.
- IN_W=1, IN_H=2. Inputs (127,idx1), (-128,idx2).
  - Outputs 0,127,0,0,0,0,-128,0. Values exact; out_last only on the final output.
- Back-pressure: IN_W=2, IN_H=2, out_ready toggling 1010…, plus a 5-cycle low burst.
  - Output sequence identical to the out_ready=1 run; out_data stable while stalled.
  - in_ready=0 throughout BOT.
- Reset mid-frame: assert rst_n=0 after 3 outputs.
  - Next cycle: out_valid=0, out_data=0, in_ready=0.
  - The following frame starts at row0/col0 and matches golden output.
- Back-to-back frames, IN_W=IN_H=14, random data/idx, out_ready=1.
  - 784 outputs per frame; frame_done pulses exactly twice.
  - Scoreboard matches the reference unpool model.
